// File: rtl/mem_stall_ctrl.sv
// Data-cache miss controller for the memory stage.
// Detects a load/store miss, writes back a dirty victim line beat by beat,
// refills the requested line from main memory, updates the tag, and holds
// the whole pipeline frozen for the duration of the miss.
module mem_stall_ctrl #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              MemReqM_i,
    input  logic                              CacheHitM_i,
    input  logic                              DirtyM_i,
    input  logic [ADDR_WIDTH-1:0]             AddrM_i,
    input  logic [ADDR_WIDTH-1:0]             VictimTag_i,
    input  logic                              MemReady_i,
    output logic                              MemReq_o,
    output logic                              MemWrite_o,
    output logic [ADDR_WIDTH-1:0]             MemAddr_o,
    output logic [$clog2(WORDS_PER_LINE)-1:0] Beat_o,
    output logic                              RefillWe_o,
    output logic                              TagWe_o,
    output logic                              StallAllM_o
);

    localparam int BEAT_W = $clog2(WORDS_PER_LINE);
    localparam int OFF_W  = BEAT_W + 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [BEAT_W-1:0]       beat_r;
    logic [ADDR_WIDTH-1:0]   miss_base_r;
    logic [ADDR_WIDTH-1:0]   victim_base_r;

    logic                    miss_s;
    logic                    last_beat_s;
    logic [ADDR_WIDTH-1:0]   line_mask_s;
    logic [ADDR_WIDTH-1:0]   beat_offset_s;

    assign miss_s        = MemReqM_i & ~CacheHitM_i;
    assign last_beat_s   = (beat_r == BEAT_W'(WORDS_PER_LINE - 1));
    // Clears the byte-in-word and word-in-line bits to get a line base.
    assign line_mask_s   = {{(ADDR_WIDTH-OFF_W){1'b1}}, {OFF_W{1'b0}}};
    assign beat_offset_s = {{(ADDR_WIDTH-OFF_W){1'b0}}, beat_r, 2'b00};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; bursts advance only on beats accepted by memory.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (miss_s) begin
                    next_state_s = DirtyM_i ? WRITEBACK : REFILL;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WRITEBACK: begin
                if (MemReady_i && last_beat_s) begin
                    next_state_s = REFILL;
                end else begin
                    next_state_s = WRITEBACK;
                end
            end
            REFILL: begin
                if (MemReady_i && last_beat_s) begin
                    next_state_s = UPDATE;
                end else begin
                    next_state_s = REFILL;
                end
            end
            UPDATE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Beat counter: cleared on the miss edge, steps on each accepted beat,
    // wraps after the last beat so the refill burst starts again at word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_r <= {BEAT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    beat_r <= {BEAT_W{1'b0}};
                end
                WRITEBACK, REFILL: begin
                    if (MemReady_i) begin
                        beat_r <= last_beat_s ? {BEAT_W{1'b0}} : beat_r + BEAT_W'(1);
                    end else begin
                        beat_r <= beat_r;
                    end
                end
                default: begin
                    beat_r <= {BEAT_W{1'b0}};
                end
            endcase
        end
    end

    // Capture miss and victim line bases on the miss edge; the stage inputs
    // are free to change while the burst runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_base_r   <= {ADDR_WIDTH{1'b0}};
            victim_base_r <= {ADDR_WIDTH{1'b0}};
        end else if (state_r == IDLE && miss_s) begin
            miss_base_r   <= AddrM_i & line_mask_s;
            victim_base_r <= VictimTag_i & line_mask_s;
        end else begin
            miss_base_r   <= miss_base_r;
            victim_base_r <= victim_base_r;
        end
    end

    // Output decode. The IDLE stall is combinational so the miss freezes the
    // pipeline in its own cycle; it is masked by rst so reset forces all zeros.
    always_comb begin
        MemReq_o    = 1'b0;
        MemWrite_o  = 1'b0;
        MemAddr_o   = {ADDR_WIDTH{1'b0}};
        Beat_o      = beat_r;
        RefillWe_o  = 1'b0;
        TagWe_o     = 1'b0;
        StallAllM_o = 1'b0;
        case (state_r)
            IDLE: begin
                StallAllM_o = miss_s & ~rst;
            end
            WRITEBACK: begin
                MemReq_o    = 1'b1;
                MemWrite_o  = 1'b1;
                MemAddr_o   = victim_base_r + beat_offset_s;
                StallAllM_o = 1'b1;
            end
            REFILL: begin
                MemReq_o    = 1'b1;
                MemAddr_o   = miss_base_r + beat_offset_s;
                RefillWe_o  = MemReady_i;
                StallAllM_o = 1'b1;
            end
            UPDATE: begin
                TagWe_o     = 1'b1;
                StallAllM_o = 1'b1;
            end
            default: begin
                StallAllM_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl. A transaction-level reference model
// (remaining write/read beat counts plus a pending-update flag) predicts every
// output each cycle; directed scenarios add explicit address/count checks.
module tb_mem_stall_ctrl;

    localparam int W  = 4;
    localparam int AW = 32;
    localparam logic [AW-1:0] LINE_MASK = 32'hFFFF_FFF0;

    logic          clk;
    logic          rst;
    logic          MemReqM_i;
    logic          CacheHitM_i;
    logic          DirtyM_i;
    logic [AW-1:0] AddrM_i;
    logic [AW-1:0] VictimTag_i;
    logic          MemReady_i;
    logic          MemReq_o;
    logic          MemWrite_o;
    logic [AW-1:0] MemAddr_o;
    logic [1:0]    Beat_o;
    logic          RefillWe_o;
    logic          TagWe_o;
    logic          StallAllM_o;

    mem_stall_ctrl #(.WORDS_PER_LINE(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .MemReqM_i(MemReqM_i), .CacheHitM_i(CacheHitM_i), .DirtyM_i(DirtyM_i),
        .AddrM_i(AddrM_i), .VictimTag_i(VictimTag_i), .MemReady_i(MemReady_i),
        .MemReq_o(MemReq_o), .MemWrite_o(MemWrite_o), .MemAddr_o(MemAddr_o),
        .Beat_o(Beat_o), .RefillWe_o(RefillWe_o), .TagWe_o(TagWe_o),
        .StallAllM_o(StallAllM_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int            wb_left = 0;
    int            rf_left = 0;
    bit            upd     = 1'b0;
    logic [AW-1:0] mb      = '0;
    logic [AW-1:0] vb      = '0;

    logic [38:0] got_vec;
    logic [38:0] exp_vec;
    assign got_vec = {MemReq_o, MemWrite_o, MemAddr_o, Beat_o, RefillWe_o, TagWe_o, StallAllM_o};

    // Predicted outputs for the current cycle from the model and live inputs.
    task automatic eval_model();
        logic          e_req, e_wr, e_rwe, e_twe, e_stall;
        logic [AW-1:0] e_addr;
        logic [1:0]    e_beat;
        int            done_beats;
        e_req = 0; e_wr = 0; e_rwe = 0; e_twe = 0; e_stall = 0; e_addr = '0; e_beat = '0;
        if (!rst) begin
            if (wb_left > 0) begin
                done_beats = W - wb_left;
                e_req = 1; e_wr = 1; e_stall = 1;
                e_beat = 2'(done_beats);
                e_addr = vb + AW'(4 * done_beats);
            end else if (rf_left > 0) begin
                done_beats = W - rf_left;
                e_req = 1; e_stall = 1; e_rwe = MemReady_i;
                e_beat = 2'(done_beats);
                e_addr = mb + AW'(4 * done_beats);
            end else if (upd) begin
                e_twe = 1; e_stall = 1;
            end else begin
                e_stall = MemReqM_i & ~CacheHitM_i;
            end
        end
        exp_vec = {e_req, e_wr, e_addr, e_beat, e_rwe, e_twe, e_stall};
    endtask

    // Advance the model across one rising edge using the inputs held there.
    task automatic model_step();
        if (rst) begin
            wb_left = 0; rf_left = 0; upd = 0; mb = '0; vb = '0;
        end else if (wb_left > 0) begin
            if (MemReady_i) begin
                wb_left--;
                if (wb_left == 0) rf_left = W;
            end
        end else if (rf_left > 0) begin
            if (MemReady_i) begin
                rf_left--;
                if (rf_left == 0) upd = 1;
            end
        end else if (upd) begin
            upd = 0;
        end else if (MemReqM_i && !CacheHitM_i) begin
            mb = AddrM_i & LINE_MASK;
            vb = VictimTag_i & LINE_MASK;
            if (DirtyM_i) wb_left = W;
            else rf_left = W;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic req, input logic hit, input logic dirty,
                         input logic [AW-1:0] addr, input logic [AW-1:0] victim,
                         input logic ready);
        MemReqM_i = req; CacheHitM_i = hit; DirtyM_i = dirty;
        AddrM_i = addr; VictimTag_i = victim; MemReady_i = ready;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'(c), $urandom, $urandom, 1'b1);
            #1;
            checks++;
            if (got_vec !== 39'd0) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h expected 0", c, got_vec);
            end
            tick();
        end
    endtask

    task automatic test_hit();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b1, 1'($urandom), $urandom, $urandom, 1'($urandom));
            #1; eval_model();
            checks++;
            if (got_vec !== exp_vec || StallAllM_o !== 1'b0 || MemReq_o !== 1'b0) begin
                errors++;
                $display("FAIL hit cycle %0d: got %h expected %h", c, got_vec, exp_vec);
            end
            tick();
        end
    endtask

    task automatic test_clean_miss();
        logic [AW-1:0] addrs[$];
        int stall_cnt = 0, twe_cnt = 0;
        bit served = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, served, 1'b0, 32'h0000_1234, 32'h0000_9990, 1'b1);
            #1; eval_model();
            checks++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("FAIL clean_miss cycle %0d: got %h expected %h", c, got_vec, exp_vec);
            end
            if (StallAllM_o) stall_cnt++;
            if (TagWe_o) twe_cnt++;
            if (RefillWe_o) addrs.push_back(MemAddr_o);
            if (TagWe_o) served = 1;
            tick();
        end
        checks++;
        if (stall_cnt != 6 || twe_cnt != 1) begin
            errors++;
            $display("FAIL clean_miss_counts: stall=%0d tagwe=%0d expected 6 and 1", stall_cnt, twe_cnt);
        end
        checks++;
        if (addrs.size() != 4 || addrs[0] !== 32'h1230 || addrs[1] !== 32'h1234 ||
            addrs[2] !== 32'h1238 || addrs[3] !== 32'h123C) begin
            errors++;
            $display("FAIL clean_miss_addrs: got %0d beats %p expected 1230 1234 1238 123c", addrs.size(), addrs);
        end
    endtask

    task automatic test_dirty_miss();
        logic [AW-1:0] waddrs[$];
        logic [AW-1:0] raddrs[$];
        int stall_cnt = 0;
        bit served = 0;
        bit ok = 1;
        for (int c = 0; c < 13; c++) begin
            drive(1'b1, served, 1'b1, 32'h0000_0040, 32'h0000_8000, 1'b1);
            #1; eval_model();
            checks++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("FAIL dirty_miss cycle %0d: got %h expected %h", c, got_vec, exp_vec);
            end
            if (StallAllM_o) stall_cnt++;
            if (MemReq_o && MemWrite_o) waddrs.push_back(MemAddr_o);
            if (MemReq_o && !MemWrite_o) raddrs.push_back(MemAddr_o);
            if (TagWe_o) served = 1;
            tick();
        end
        if (waddrs.size() != 4 || raddrs.size() != 4) ok = 0;
        for (int i = 0; i < 4 && ok; i++) begin
            if (waddrs[i] !== 32'h8000 + AW'(4 * i) || raddrs[i] !== 32'h40 + AW'(4 * i)) ok = 0;
        end
        checks++;
        if (!ok || stall_cnt != 10) begin
            errors++;
            $display("FAIL dirty_miss_seq: stall=%0d (expected 10) writes=%p reads=%p", stall_cnt, waddrs, raddrs);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] beats[$];
        logic [AW-1:0] base;
        bit served = 0;
        int c;
        base = $urandom;
        for (c = 0; c < 40 && !served; c++) begin
            drive(1'b1, 1'b0, 1'b0, base, 32'h0, 1'(c % 4 == 3));
            #1; eval_model();
            checks++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("FAIL backpressure cycle %0d: got %h expected %h", c, got_vec, exp_vec);
            end
            if (RefillWe_o) beats.push_back(Beat_o);
            if (TagWe_o) served = 1;
            tick();
        end
        checks++;
        if (!served || beats.size() != 4 || beats[0] !== 2'd0 || beats[1] !== 2'd1 ||
            beats[2] !== 2'd2 || beats[3] !== 2'd3) begin
            errors++;
            $display("FAIL backpressure_beats: served=%0d beats=%p expected 0 1 2 3", served, beats);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_refill();
        logic [AW-1:0] first_addr;
        bit seen = 0;
        bit served = 0;
        first_addr = '0;
        for (int c = 0; c < 14; c++) begin
            drive(1'b1, served, 1'b0, 32'h0000_ABC8, 32'h0, 1'b1);
            rst = (c == 3);
            #1; eval_model();
            checks++;
            if (got_vec !== exp_vec || (rst && got_vec !== 39'd0)) begin
                errors++;
                $display("FAIL reset_mid_refill cycle %0d: got %h expected %h", c, got_vec, exp_vec);
            end
            if (c > 3 && MemReq_o && !seen) begin
                first_addr = MemAddr_o;
                seen = 1;
            end
            if (TagWe_o) served = 1;
            tick();
        end
        rst = 1'b0;
        checks++;
        if (!seen || first_addr !== 32'h0000_ABC0) begin
            errors++;
            $display("FAIL reset_restart_addr: got %h expected 0000abc0", first_addr);
        end
    endtask

    task automatic test_input_change();
        logic [AW-1:0] base;
        logic [AW-1:0] addrs[$];
        bit served = 0;
        bit ok;
        base = $urandom & LINE_MASK;
        for (int c = 0; c < 60 && !served; c++) begin
            if (rf_left > 0) drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom));
            else drive(1'b1, 1'b0, 1'b0, base | 32'h4, 32'h0, 1'($urandom));
            #1; eval_model();
            checks++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("FAIL input_change cycle %0d: got %h expected %h", c, got_vec, exp_vec);
            end
            if (RefillWe_o) addrs.push_back(MemAddr_o);
            if (TagWe_o) served = 1;
            tick();
        end
        ok = served && addrs.size() == 4;
        for (int i = 0; i < 4 && ok; i++) if (addrs[i] !== base + AW'(4 * i)) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL input_change_addrs: base %h got %p", base, addrs);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            drive(1'($urandom), ($urandom % 3) == 0, 1'($urandom), $urandom, $urandom, 1'($urandom));
            rst = ($urandom % 150) == 0;
            #1; eval_model();
            checks++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", c, got_vec, exp_vec);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_hit();
        test_clean_miss();
        test_dirty_miss();
        test_backpressure();
        test_reset_mid_refill();
        test_input_change();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
